// File: rtl/tl_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tl_cmd_sequencer_pkg
// Brief    : TL-UL widths, opcodes and sequencer types shared by the command
//            sequencer and its FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package tl_cmd_sequencer_pkg;

  localparam int TL_ADDR_BITS   = 32;
  localparam int TL_SIZE_BITS   = 2;
  localparam int TL_SOURCE_BITS = 4;
  localparam int TL_DATA_BYTES  = 4;
  localparam int TL_DATA_BITS   = TL_DATA_BYTES * 8;

  localparam logic [1:0] TL_OP_GET        = 2'd0;
  localparam logic [1:0] TL_OP_PUTFULL    = 2'd1;
  localparam logic [1:0] TL_OP_PUTPARTIAL = 2'd2;
  localparam logic [1:0] TL_OP_RSV        = 2'd3;

  typedef enum logic [1:0] {
    TL_SEQ_IDLE  = 2'd0,
    TL_SEQ_ISSUE = 2'd1,
    TL_SEQ_WAIT  = 2'd2,
    TL_SEQ_RESP  = 2'd3
  } tl_seq_state_e;

  typedef struct packed {
    logic [1:0]                op;
    logic [TL_ADDR_BITS-1:0]   addr;
    logic [TL_SIZE_BITS-1:0]   size;
    logic [TL_SOURCE_BITS-1:0] source;
    logic [TL_DATA_BITS-1:0]   data;
    logic [TL_DATA_BYTES-1:0]  mask;
  } tl_seq_cmd_t;

  localparam int TL_SEQ_CMD_BITS = $bits(tl_seq_cmd_t);

  function automatic logic tl_op_is_put(input logic [1:0] op);
    return (op == TL_OP_PUTFULL) || (op == TL_OP_PUTPARTIAL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tl_seq_fifo
// Brief    : Synchronous show-ahead FIFO holding queued sequencer commands.
// Revision : 1.0 - initial release
// ============================================================================
module tl_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tl_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tl_cmd_sequencer
// Brief    : Queues TL-UL commands and runs them one at a time through the L1
//            adapter. Optional WAIT watchdog enabled by TL_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tl_cmd_sequencer
  import tl_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_type,
  input  logic [TL_ADDR_BITS-1:0]   cmd_addr,
  input  logic [TL_SIZE_BITS-1:0]   cmd_size,
  input  logic [TL_SOURCE_BITS-1:0] cmd_source,
  input  logic [TL_DATA_BITS-1:0]   cmd_data,
  input  logic [TL_DATA_BYTES-1:0]  cmd_mask,
  output logic                      start_transaction,
  output logic [1:0]                transaction_type,
  output logic [TL_ADDR_BITS-1:0]   address,
  output logic [TL_SIZE_BITS-1:0]   size,
  output logic [TL_SOURCE_BITS-1:0] source,
  output logic [TL_DATA_BITS-1:0]   write_data,
  output logic [TL_DATA_BYTES-1:0]  write_mask,
  input  logic                      transaction_done,
  input  logic [TL_DATA_BITS-1:0]   read_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [1:0]                rsp_type,
  output logic [TL_SOURCE_BITS-1:0] rsp_source,
  output logic [TL_DATA_BITS-1:0]   rsp_data,
  output logic                      rsp_error,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  tl_seq_cmd_t                cmd_in;
  tl_seq_cmd_t                head;
  logic [TL_SEQ_CMD_BITS-1:0] fifo_dout;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_pop;
  tl_seq_state_e              state;

`ifdef TL_SEQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] wait_timer;
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

  assign cmd_in    = {cmd_type, cmd_addr, cmd_size, cmd_source, cmd_data, cmd_mask};
  assign head      = fifo_dout;
  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state == TL_SEQ_IDLE) && !fifo_empty;
  assign busy      = (state != TL_SEQ_IDLE) || !fifo_empty;

  tl_seq_fifo #(
    .WIDTH (TL_SEQ_CMD_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid && !fifo_full),
    .pop   (fifo_pop),
    .din   (cmd_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= TL_SEQ_IDLE;
      start_transaction <= 1'b0;
      transaction_type  <= '0;
      address           <= '0;
      size              <= '0;
      source            <= '0;
      write_data        <= '0;
      write_mask        <= '0;
      rsp_valid         <= 1'b0;
      rsp_type          <= '0;
      rsp_source        <= '0;
      rsp_data          <= '0;
      rsp_error         <= 1'b0;
`ifdef TL_SEQ_TIMEOUT_EN
      wait_timer        <= '0;
`endif
    end else begin
      start_transaction <= 1'b0;
      case (state)
        TL_SEQ_IDLE: begin
          if (!fifo_empty) begin
            transaction_type <= head.op;
            address          <= head.addr;
            size             <= head.size;
            source           <= head.source;
            write_data       <= head.data;
            write_mask       <= head.mask;
            rsp_type         <= head.op;
            rsp_source       <= head.source;
            rsp_data         <= '0;
            // Reserved opcodes never reach the adapter.
            if (head.op == TL_OP_RSV) begin
              rsp_error <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= TL_SEQ_RESP;
            end else begin
              rsp_error         <= 1'b0;
              start_transaction <= 1'b1;
              state             <= TL_SEQ_ISSUE;
            end
          end
        end
        TL_SEQ_ISSUE: begin
`ifdef TL_SEQ_TIMEOUT_EN
          wait_timer <= '0;
`endif
          state <= TL_SEQ_WAIT;
        end
        TL_SEQ_WAIT: begin
          if (transaction_done) begin
            rsp_data  <= tl_op_is_put(transaction_type) ? '0 : read_data;
            rsp_valid <= 1'b1;
            state     <= TL_SEQ_RESP;
          end
`ifdef TL_SEQ_TIMEOUT_EN
          else if (wait_timer == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_data  <= '0;
            rsp_error <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= TL_SEQ_RESP;
          end else begin
            wait_timer <= wait_timer + TMO_W'(1);
          end
`endif
        end
        TL_SEQ_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= TL_SEQ_IDLE;
          end
        end
        default: state <= TL_SEQ_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tl_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_cmd_sequencer
// Brief    : Scoreboard bench for tl_cmd_sequencer with an adapter stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_cmd_sequencer;
  import tl_cmd_sequencer_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      cmd_valid, cmd_ready;
  logic [1:0]                cmd_type;
  logic [TL_ADDR_BITS-1:0]   cmd_addr;
  logic [TL_SIZE_BITS-1:0]   cmd_size;
  logic [TL_SOURCE_BITS-1:0] cmd_source;
  logic [TL_DATA_BITS-1:0]   cmd_data;
  logic [TL_DATA_BYTES-1:0]  cmd_mask;
  logic                      start_transaction;
  logic [1:0]                transaction_type;
  logic [TL_ADDR_BITS-1:0]   address;
  logic [TL_SIZE_BITS-1:0]   size;
  logic [TL_SOURCE_BITS-1:0] source;
  logic [TL_DATA_BITS-1:0]   write_data;
  logic [TL_DATA_BYTES-1:0]  write_mask;
  logic                      transaction_done;
  logic [TL_DATA_BITS-1:0]   read_data;
  logic                      rsp_valid, rsp_ready;
  logic [1:0]                rsp_type;
  logic [TL_SOURCE_BITS-1:0] rsp_source;
  logic [TL_DATA_BITS-1:0]   rsp_data;
  logic                      rsp_error, busy;
  logic [$clog2(DEPTH):0]    fifo_count;

  always #5 clk = ~clk;

  tl_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_source(cmd_source),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .start_transaction(start_transaction), .transaction_type(transaction_type),
    .address(address), .size(size), .source(source),
    .write_data(write_data), .write_mask(write_mask),
    .transaction_done(transaction_done), .read_data(read_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_type(rsp_type),
    .rsp_source(rsp_source), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .busy(busy), .fifo_count(fifo_count)
  );

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  src;
    logic [31:0] data;
    logic        err;
    logic        tmo;
  } exp_rsp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  src;
    logic [31:0] data;
    logic [3:0]  mask;
  } exp_start_t;

  exp_rsp_t   exp_rsp[$];
  exp_start_t exp_start[$];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int done_cnt = 0, done_cyc = 0, last_start_cyc = 0;
  int done_req = 0, done_ack = 0;
  int rsp_cnt  = 0;
  bit hang     = 1'b0;
  int lat      = 3;

  logic [121:0] reset_vec;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [121:0] outs();
    return {cmd_ready, start_transaction, busy, rsp_valid, rsp_error, fifo_count,
            transaction_type, address, size, source, write_data, write_mask,
            rsp_type, rsp_source, rsp_data};
  endfunction

  // Adapter stub: checks each issued transaction, models memory, pulses done.
  initial begin
    exp_start_t  e;
    logic [31:0] rd, cur;
    logic [31:0] mem [logic [31:0]];
    transaction_done = 1'b0;
    read_data        = '0;
    forever begin
      @(negedge clk);
      if (rst_n && start_transaction) begin
        last_start_cyc = cyc;
        if (exp_start.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL start_unexpected: got start addr 0x%0h, required no start", address);
        end else begin
          e = exp_start.pop_front();
          check("start_type",   transaction_type, e.op);
          check("start_addr",   address,          e.addr);
          check("start_size",   size,             e.size);
          check("start_source", source,           e.src);
          check("start_wdata",  write_data,       e.data);
          check("start_wmask",  write_mask,       e.mask);
        end
        if (!hang) begin
          if (transaction_type == TL_OP_GET) begin
            rd = mem.exists(address) ? mem[address] : 32'h0;
          end else begin
            cur = mem.exists(address) ? mem[address] : 32'h0;
            for (int b = 0; b < 4; b++)
              if (write_mask[b]) cur[b*8 +: 8] = write_data[b*8 +: 8];
            mem[address] = cur;
            rd = 32'hFFFF_FFFF;
          end
          repeat (lat) @(posedge clk);
          #1;
          transaction_done = 1'b1;
          read_data        = rd;
          done_cnt++;
          done_cyc = cyc;
          @(posedge clk);
          #1;
          transaction_done = 1'b0;
          read_data        = '0;
        end
      end else if (done_req != done_ack) begin
        done_ack++;
        @(posedge clk);
        #1;
        transaction_done = 1'b1;
        read_data        = 32'h5A5A_5A5A;
        @(posedge clk);
        #1;
        transaction_done = 1'b0;
        read_data        = '0;
      end
    end
  end

  // Response monitor: latency on rsp_valid rise, field checks on handshake.
  initial begin
    exp_rsp_t e;
    int       seen_done;
    logic     prev_valid;
    seen_done  = 0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        continue;
      end
      if (rsp_valid && !prev_valid) begin
        if (done_cnt != seen_done) begin
          check("rsp_latency_done", cyc, done_cyc + 1);
          seen_done = done_cnt;
        end else if (exp_rsp.size() > 0 && exp_rsp[0].tmo) begin
          check("rsp_latency_timeout", cyc, last_start_cyc + TMO + 1);
        end
      end
      prev_valid = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (exp_rsp.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL rsp_unexpected: got response source %0d, required none", rsp_source);
        end else begin
          e = exp_rsp.pop_front();
          check("rsp_type",   rsp_type,   e.op);
          check("rsp_source", rsp_source, e.src);
          check("rsp_data",   rsp_data,   e.data);
          check("rsp_error",  rsp_error,  e.err);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [1:0] sz,
                      input logic [3:0] src, input logic [31:0] d, input logic [3:0] m,
                      input logic [31:0] exp_data, input logic exp_err, input logic tmo);
    bit ok;
    if (op != TL_OP_RSV) exp_start.push_back('{op, a, sz, src, d, m});
    exp_rsp.push_back('{op, src, exp_data, exp_err, tmo});
    cmd_valid  = 1'b1;
    cmd_type   = op;
    cmd_addr   = a;
    cmd_size   = sz;
    cmd_source = src;
    cmd_data   = d;
    cmd_mask   = m;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fails++;
      $display("FAIL cmd_handshake: got no cmd_ready in 200 cycles, required accept");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (!busy && exp_rsp.size() == 0 && exp_start.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fails++;
      $display("FAIL wait_idle: got busy=%0b pending=%0d, required idle", busy, exp_rsp.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fails++;
      $display("FAIL wait_rsp_valid: got rsp_valid=0 for 100 cycles, required 1");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int rc;
    reset_vec  = {1'b1, 121'd0};
    cmd_valid  = 1'b0;
    cmd_type   = '0;
    cmd_addr   = '0;
    cmd_size   = '0;
    cmd_source = '0;
    cmd_data   = '0;
    cmd_mask   = '0;
    rsp_ready  = 1'b0;

    @(posedge clk);
    #1;
    check("reset_outputs", outs(), reset_vec);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // PUTFULL then GET of the same address
    rsp_ready = 1'b1;
    lat       = 3;
    send(TL_OP_PUTFULL, 32'h10, 2'd2, 4'd2, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("start_low_n1", start_transaction, 1'b0);
    @(negedge clk);
    check("start_high_n2", start_transaction, 1'b1);
    wait_idle();
    send(TL_OP_GET, 32'h10, 2'd2, 4'd3, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    wait_idle();

    // Five commands against a stalled consumer
    rsp_ready = 1'b0;
    lat       = 2;
    send(TL_OP_PUTFULL,    32'h20, 2'd2, 4'd0, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 1'b0);
    send(TL_OP_PUTPARTIAL, 32'h20, 2'd1, 4'd1, 32'h2222_2222, 4'h3, 32'h0, 1'b0, 1'b0);
    send(TL_OP_GET,        32'h20, 2'd2, 4'd2, 32'h0,         4'h0, 32'h1111_2222, 1'b0, 1'b0);
    send(TL_OP_PUTFULL,    32'h24, 2'd2, 4'd3, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, 1'b0);
    send(TL_OP_GET,        32'h24, 2'd2, 4'd4, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0, 1'b0);
    wait_rsp_valid();
    check("full_count", fifo_count, 3'd4);
    check("full_cmd_ready", cmd_ready, 1'b0);
    check("full_busy", busy, 1'b1);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_idle();
    check("drain_count", fifo_count, 3'd0);
    check("drain_busy", busy, 1'b0);

    // Reserved opcode
    send(TL_OP_RSV, 32'h40, 2'd0, 4'd7, 32'h1234, 4'hF, 32'h0, 1'b1, 1'b0);
    wait_idle();

    // Reset during WAIT with two commands queued
    hang = 1'b1;
    send(TL_OP_PUTFULL, 32'h50, 2'd2, 4'd8, 32'h0000_0050, 4'hF, 32'h0, 1'b0, 1'b0);
    send(TL_OP_PUTFULL, 32'h54, 2'd2, 4'd9, 32'h0000_0054, 4'hF, 32'h0, 1'b0, 1'b0);
    send(TL_OP_PUTFULL, 32'h58, 2'd2, 4'd10, 32'h0000_0058, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_reset_count", fifo_count, 3'd2);
    #1 rst_n = 1'b0;
    #1;
    check("midwait_reset_outputs", outs(), reset_vec);
    exp_rsp.delete();
    exp_start.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    hang = 1'b0;
    rc = rsp_cnt;
    done_req++;
    repeat (10) @(posedge clk);
    #1;
    check("no_rsp_after_reset", rsp_cnt, rc);
    check("outputs_after_late_done", outs(), reset_vec);

`ifdef TL_SEQ_TIMEOUT_EN
    // Adapter never completes: watchdog, then a late done, then a normal command
    rsp_ready = 1'b0;
    hang      = 1'b1;
    lat       = 3;
    send(TL_OP_GET,     32'h10, 2'd2, 4'd5, 32'h0,         4'h0, 32'h0, 1'b1, 1'b1);
    send(TL_OP_PUTFULL, 32'h30, 2'd2, 4'd6, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b0);
    wait_rsp_valid();
    done_req++;
    repeat (4) @(posedge clk);
    #1;
    hang      = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    send(TL_OP_GET, 32'h30, 2'd2, 4'd11, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
    wait_idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tl_cmd_sequencer.md
Name: tl_cmd_sequencer

Overview:
- Command front-end directly upstream of the TL-UL L1 (master) adapter inside tl_top.
- Buffers GET/PUTFULL/PUTPARTIAL commands from a valid/ready producer, e.g. a CPU-side stub or DMA stub.
- Drives the adapter's start_transaction/transaction_done control interface, one transaction outstanding at a time.
- Returns per-command responses, including read data, on a valid/ready response port.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 256, WAIT-state watchdog limit; used only with TL_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_type  in  2  0 GET, 1 PUTFULL, 2 PUTPARTIAL, 3 reserved.
- cmd_addr  in  TL_ADDR_BITS  address.
- cmd_size  in  TL_SIZE_BITS  log2 bytes.
- cmd_source  in  TL_SOURCE_BITS  source ID.
- cmd_data  in  TL_DATA_BYTES*8  write data.
- cmd_mask  in  TL_DATA_BYTES  byte mask (PUTPARTIAL).
- start_transaction  out  1  one-cycle pulse to L1 adapter.
- transaction_type, address, size, source, write_data, write_mask  out  as cmd_*  to L1 adapter.
- transaction_done  in  1  adapter completion pulse.
- read_data  in  TL_DATA_BYTES*8  adapter GET result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts.
- rsp_type  out  2  echo of cmd_type.
- rsp_source  out  TL_SOURCE_BITS  echo of cmd_source.
- rsp_data  out  TL_DATA_BYTES*8  GET data; 0 for puts and errors.
- rsp_error  out  1  reserved type or timeout.
- busy  out  1  state != IDLE or FIFO non-empty.
- fifo_count  out  log2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs are 0, except cmd_ready, which is 1.
  - FIFO is emptied; state = IDLE.
  - Reset mid-WAIT abandons the transaction; the adapter shares rst_n.
- FIFO push when cmd_valid & cmd_ready; pop when IDLE & !empty.
- Simultaneous push and pop leaves the count unchanged.
- When full, cmd_ready = 0; a pop this cycle raises cmd_ready the next cycle. There is no combinational ready path.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If FIFO non-empty, pop the head into a command register.
  - Type 3: go to RESP with rsp_error = 1, no adapter activity.
  - Types 0–2: go to ISSUE.
- ISSUE:
  - start_transaction = 1 for exactly this cycle; go to WAIT.
  - transaction_done is ignored in ISSUE.
- WAIT:
  - On transaction_done, capture read_data (GET) or 0 (puts) into rsp_data; go to RESP.
- RESP:
  - rsp_valid = 1, with all rsp_* fields stable until rsp_ready.
  - On handshake go to IDLE and drop rsp_valid the next cycle.
- Adapter outputs (transaction_type..write_mask) are registered. They are loaded at the pop and held stable from ISSUE through the end of WAIT.
- Latency: command handshake at edge N; start_transaction is high during cycle N+2 (IDLE pop in N+1). With done at edge D, rsp_valid rises at D+1.
- Back-to-back commands: minimum 4 cycles per command plus adapter latency; no overlap of transactions.
- transaction_done outside WAIT (spurious or late) is ignored.

Optional Feature:
- Macro TL_SEQ_TIMEOUT_EN, compiled in:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES - 1 without done, the FSM goes to RESP with rsp_error = 1 and rsp_data = 0.
  - done on that same cycle takes priority (normal response).
- Macro absent: WAIT is unbounded, no counter logic exists, and rsp_error is asserted only for type 3.

Decomposition:
- Additions to tl_pkg.vh:
  - TL_OP_GET = 2'd0, TL_OP_PUTFULL = 2'd1, TL_OP_PUTPARTIAL = 2'd2, TL_OP_RSV = 2'd3.
  - Sequencer state encodings TL_SEQ_IDLE/ISSUE/WAIT/RESP (2 bits).
- Sub-module tl_seq_fifo:
  - Synchronous FIFO; parameters WIDTH and DEPTH.
  - Ports push, pop, din, dout (head, show-ahead), full, empty, count.
  - Instantiated once with WIDTH = 2 + ADDR + SIZE + SOURCE + DATA + MASK.

Test Plan:
- PUTFULL addr 0x10, data 0xDEADBEEF, mask 0xF; adapter done 3 cycles after start:
  - start_transaction is high during cycle N+2 with the fields as given.
  - rsp_valid rises one cycle after done, with rsp_type = 1, rsp_data = 0, rsp_error = 0.
- GET addr 0x10 after the PUT above:
  - read_data = 0xDEADBEEF captured.
  - rsp_data = 0xDEADBEEF; rsp_source echoes 3.
- Push 5 commands with rsp_ready = 0, DEPTH = 4:
  - cmd_ready drops once fifo_count = 4 with the first command held in RESP.
  - Raise rsp_ready: all five complete in order; fifo_count returns to 0; busy returns to 0.
- cmd_type = 3, source 7:
  - No start_transaction.
  - Response has rsp_error = 1, rsp_source = 7, rsp_data = 0.
- Assert rst_n = 0 during WAIT with 2 entries queued:
  - All outputs go to 0 (cmd_ready = 1) and fifo_count = 0.
  - A transaction_done pulse after reset produces no response.
- With TL_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES = 8, adapter never completes:
  - rsp_error = 1 exactly 8 WAIT cycles after ISSUE.
  - A later done is ignored, and the next queued command issues normally.
